// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding, the reset vector and the AXI-lite
// OKAY response code.

package ifu_pkg;

    localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4
    } ifu_state_e;

    // True when a fetch address is 4-byte aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_inst_buf.sv
// ifu_inst_buf: instruction hold register for the fetch stage.
// Captures the fetched instruction on load and presents it with a
// valid/ready handshake until the consumer takes it. The instruction value
// itself is only cleared by reset; outside a valid window it keeps the last
// fetched word.

module ifu_inst_buf #(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [IW-1:0] load_data,
    input  logic          inst_ready,
    output logic [IW-1:0] inst,
    output logic          inst_valid
);

    logic [IW-1:0] inst_r;
    logic          valid_r;

    // Load the instruction and raise valid; drop valid once it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_r  <= {IW{1'b0}};
            valid_r <= 1'b0;
        end else if (load) begin
            inst_r  <= load_data;
            valid_r <= 1'b1;
        end else if (valid_r && inst_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign inst       = inst_r;
    assign inst_valid = valid_r;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage of the single-cycle core.
// Requests the current PC over an AXI-lite style read channel, extracts the
// 32-bit instruction from the returned doubleword, holds it for the consumer,
// then pulses pc_ld so the PC generator advances. One boot pc_ld pulse is
// issued after reset to move the PC generator onto the reset vector.
// Optional feature macro: IFU_FAULT_CHECK_EN (misaligned-PC and read-response
// checking with a sticky fetch_err and a terminal ERR state).

import ifu_pkg::*;

module ifu_fetch #(
    parameter int DW = 64,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pc,
    output logic          pc_ld,
    output logic [DW-1:0] araddr,
    output logic          arvalid,
    input  logic          arready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready,
    output logic [IW-1:0] inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic          fetch_err
);

    ifu_state_e    state_r;
    ifu_state_e    state_nxt_s;
    logic [DW-1:0] addr_r;
    logic          load_s;
    logic          arvalid_s;
    logic [IW-1:0] word_s;

    // State register; reset parks the FSM in BOOT so the boot pulse follows release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Track the request address while in AR; pc is stable until HOLD exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r <= {DW{1'b0}};
        end else if (state_r == ST_AR) begin
            addr_r <= pc;
        end
    end

    // The PC generator only updates pc at the boot pulse edge, so the first
    // AR cycle already sees the new pc; drive it straight through in AR.
    assign araddr  = (state_r == ST_AR) ? pc : addr_r;
    assign arvalid = arvalid_s;
    assign rready  = (state_r == ST_R);
    assign word_s  = addr_r[2] ? rdata[2*IW-1:IW] : rdata[IW-1:0];
    assign pc_ld   = !rst && ((state_r == ST_BOOT) || ((state_r == ST_HOLD) && inst_ready));

    // Next-state and request decode for the fetch sequence.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        arvalid_s   = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_AR;
            end
            ST_AR: begin
`ifdef IFU_FAULT_CHECK_EN
                if (!is_word_aligned(pc[1:0])) begin
                    state_nxt_s = ST_ERR;
                end else begin
                    arvalid_s = 1'b1;
                    if (arready) begin
                        state_nxt_s = ST_R;
                    end else begin
                        state_nxt_s = ST_AR;
                    end
                end
`else
                arvalid_s = 1'b1;
                if (arready) begin
                    state_nxt_s = ST_R;
                end else begin
                    state_nxt_s = ST_AR;
                end
`endif
            end
            ST_R: begin
                if (rvalid) begin
`ifdef IFU_FAULT_CHECK_EN
                    if (rresp != RESP_OKAY) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end
`else
                    load_s      = 1'b1;
                    state_nxt_s = ST_HOLD;
`endif
                end else begin
                    state_nxt_s = ST_R;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    state_nxt_s = ST_AR;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
`ifdef IFU_FAULT_CHECK_EN
            ST_ERR: begin
                state_nxt_s = ST_ERR;
            end
`endif
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

`ifdef IFU_FAULT_CHECK_EN
    logic err_r;

    // Sticky fault flag, set on entry to ERR and held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (state_nxt_s == ST_ERR) begin
            err_r <= 1'b1;
        end
    end

    assign fetch_err = err_r;
`else
    // Response code is not inspected when fault checking is compiled out.
    logic unused_rresp_s;
    assign unused_rresp_s = ^rresp;
    assign fetch_err      = 1'b0;
`endif

    ifu_inst_buf #(
        .IW (IW)
    ) u_inst_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_data  (word_s),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

endmodule
